// File: rtl/fifo_wr_arb.sv
// ============================================================================
// Module  : fifo_wr_arb
// Purpose : Three-requester round-robin burst arbiter writing into a FIFO.
//           Optional stall counter enabled by macro FIFO_WR_ARB_STALL_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arb #(
   parameter int BURST = 4,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [2:0]    req_valid,
   input  logic [DW-1:0] req_data0,
   input  logic [DW-1:0] req_data1,
   input  logic [DW-1:0] req_data2,
   output logic [2:0]    req_ready,
   input  logic          fifo_full,
   output logic          fifo_wr_enb,
   output logic [DW-1:0] fifo_data_in,
   output logic [2:0]    grant,
   output logic          busy
`ifdef FIFO_WR_ARB_STALL_CNT_EN
   ,
   output logic [15:0]   stall_cnt
`endif
);

   localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
   localparam logic [CW-1:0] C_LAST_BEAT = CW'(BURST - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [2:0]    r_grant, w_grant_nxt;
   logic [1:0]    r_last,  w_last_nxt;
   logic [CW-1:0] r_beat,  w_beat_nxt;
   logic [2:0]    w_pick;
   logic [1:0]    w_gidx;
   logic          w_gvalid;

   assign grant       = r_grant;
   assign busy        = (r_state == GRANT);
   assign req_ready   = (r_state == GRANT && !fifo_full) ? r_grant : 3'b000;
   assign fifo_wr_enb = |(req_valid & req_ready);
   assign w_gvalid    = |(req_valid & r_grant);
   assign w_gidx      = r_grant[1] ? 2'd1 : (r_grant[2] ? 2'd2 : 2'd0);

   always_comb begin
      fifo_data_in = '0;
      case (r_grant)
         3'b001:  fifo_data_in = req_data0;
         3'b010:  fifo_data_in = req_data1;
         3'b100:  fifo_data_in = req_data2;
         default: fifo_data_in = '0;
      endcase
   end

   // Search begins at the requester following the last one granted.
   always_comb begin
      w_pick = 3'b000;
      case (r_last)
         2'd0:    w_pick = req_valid[1] ? 3'b010 : req_valid[2] ? 3'b100 :
                           req_valid[0] ? 3'b001 : 3'b000;
         2'd1:    w_pick = req_valid[2] ? 3'b100 : req_valid[0] ? 3'b001 :
                           req_valid[1] ? 3'b010 : 3'b000;
         default: w_pick = req_valid[0] ? 3'b001 : req_valid[1] ? 3'b010 :
                           req_valid[2] ? 3'b100 : 3'b000;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_last_nxt  = r_last;
      w_beat_nxt  = r_beat;
      case (r_state)
         IDLE: begin
            if (|req_valid) begin
               w_state_nxt = GRANT;
               w_grant_nxt = w_pick;
               w_beat_nxt  = '0;
            end
         end
         GRANT: begin
            if (!w_gvalid || (fifo_wr_enb && r_beat == C_LAST_BEAT)) begin
               w_state_nxt = IDLE;
               w_grant_nxt = 3'b000;
               w_last_nxt  = w_gidx;
               w_beat_nxt  = '0;
            end else if (fifo_wr_enb) begin
               w_beat_nxt  = r_beat + CW'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_grant_nxt = 3'b000;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_grant <= 3'b000;
         r_last  <= 2'd2;
         r_beat  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_last  <= w_last_nxt;
         r_beat  <= w_beat_nxt;
      end
   end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
   logic [15:0] r_stall;

   assign stall_cnt = r_stall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall <= 16'h0000;
      end else if (r_state == GRANT && w_gvalid && fifo_full && r_stall != 16'hFFFF) begin
         r_stall <= r_stall + 16'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
// ============================================================================
// Module  : tb_fifo_wr_arb
// Purpose : Self-checking bench for fifo_wr_arb (vector table, directed
//           corner sequences, randomized run against a reference model).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arb;

   localparam int BURST = 4;
   localparam int DW    = 8;

   logic          clk;
   logic          rst;
   logic [2:0]    req_valid;
   logic [DW-1:0] req_data0, req_data1, req_data2;
   logic [2:0]    req_ready;
   logic          fifo_full;
   logic          fifo_wr_enb;
   logic [DW-1:0] fifo_data_in;
   logic [2:0]    grant;
   logic          busy;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
   logic [15:0]   stall_cnt;
`endif

   fifo_wr_arb #(.BURST(BURST), .DW(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_data0    (req_data0),
      .req_data1    (req_data1),
      .req_data2    (req_data2),
      .req_ready    (req_ready),
      .fifo_full    (fifo_full),
      .fifo_wr_enb  (fifo_wr_enb),
      .fifo_data_in (fifo_data_in),
      .grant        (grant),
      .busy         (busy)
`ifdef FIFO_WR_ARB_STALL_CNT_EN
      ,
      .stall_cnt    (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: current owner (-1 = none), beats taken, last served.
   int         owner;
   int         beats;
   int         last;
   int         exp_stall;
   int         wr_seen;
   logic [2:0] grant_seen;

   typedef struct packed {
      logic [2:0] v;
      logic       f;
      logic [7:0] d0;
      logic [2:0] eg;
      logic       ew;
      logic [7:0] ed;
   } vec_t;

   vec_t tab [11];

   function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endfunction

   task automatic model_reset();
      owner     = -1;
      beats     = 0;
      last      = 2;
      exp_stall = 0;
   endtask

   task automatic do_reset();
      rst       = 1'b0;
      req_valid = 3'b111;
      fifo_full = 1'b0;
      req_data0 = 8'h11;
      req_data1 = 8'h22;
      req_data2 = 8'h33;
      repeat (2) @(posedge clk);
      #3;
      chk("rst_grant", 16'(grant), 16'h0);
      chk("rst_busy",  16'(busy), 16'h0);
      chk("rst_ready", 16'(req_ready), 16'h0);
      chk("rst_wr",    16'(fifo_wr_enb), 16'h0);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
      chk("rst_stall", stall_cnt, 16'h0);
`endif
      req_valid = 3'b000;
      rst       = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
   endtask

   // Drive one cycle, compare against the model, then advance the model.
   task automatic cycle(input logic [2:0] v, input logic f,
                        input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      logic [2:0] eg, er;
      logic       ew;
      logic [7:0] ed;
      req_valid = v;
      fifo_full = f;
      req_data0 = a;
      req_data1 = b;
      req_data2 = c;
      #2;
      eg = (owner >= 0) ? 3'(1 << owner) : 3'b000;
      er = (owner >= 0 && !f) ? eg : 3'b000;
      ew = |(v & er);
      ed = (owner == 0) ? a : (owner == 1) ? b : (owner == 2) ? c : 8'h00;
      chk("grant", 16'(grant), 16'(eg));
      chk("busy",  16'(busy), 16'(owner >= 0));
      chk("ready", 16'(req_ready), 16'(er));
      chk("wr",    16'(fifo_wr_enb), 16'(ew));
      chk("data",  16'(fifo_data_in), 16'(ed));
`ifdef FIFO_WR_ARB_STALL_CNT_EN
      chk("stall", stall_cnt, 16'(exp_stall));
`endif
      grant_seen = grant;
      if (fifo_wr_enb) wr_seen++;
      @(posedge clk);
      #1;
      if (owner < 0) begin
         if (v != 3'b000) begin
            for (int k = 1; k <= 3; k++) begin
               if (owner < 0 && v[(last + k) % 3]) owner = (last + k) % 3;
            end
            beats = 0;
         end
      end else if (!v[owner]) begin
         last  = owner;
         owner = -1;
      end else if (f) begin
         if (exp_stall < 65535) exp_stall++;
      end else begin
         beats++;
         if (beats == BURST) begin
            last  = owner;
            owner = -1;
         end
      end
   endtask

   function automatic logic [7:0] rnd8();
      return 8'($urandom);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      logic [2:0] v;
      rst       = 1'b0;
      req_valid = 3'b000;
      fifo_full = 1'b0;
      req_data0 = '0;
      req_data1 = '0;
      req_data2 = '0;
      wr_seen   = 0;
      grant_seen = 3'b000;
      model_reset();

      // Single requester streaming A0..A7 in two bursts of four.
      tab[0]  = '{3'b001, 1'b0, 8'hA0, 3'b000, 1'b0, 8'h00};
      tab[1]  = '{3'b001, 1'b0, 8'hA0, 3'b001, 1'b1, 8'hA0};
      tab[2]  = '{3'b001, 1'b0, 8'hA1, 3'b001, 1'b1, 8'hA1};
      tab[3]  = '{3'b001, 1'b0, 8'hA2, 3'b001, 1'b1, 8'hA2};
      tab[4]  = '{3'b001, 1'b0, 8'hA3, 3'b001, 1'b1, 8'hA3};
      tab[5]  = '{3'b001, 1'b0, 8'hA4, 3'b000, 1'b0, 8'h00};
      tab[6]  = '{3'b001, 1'b0, 8'hA4, 3'b001, 1'b1, 8'hA4};
      tab[7]  = '{3'b001, 1'b0, 8'hA5, 3'b001, 1'b1, 8'hA5};
      tab[8]  = '{3'b001, 1'b0, 8'hA6, 3'b001, 1'b1, 8'hA6};
      tab[9]  = '{3'b001, 1'b0, 8'hA7, 3'b001, 1'b1, 8'hA7};
      tab[10] = '{3'b000, 1'b0, 8'hA7, 3'b000, 1'b0, 8'h00};

      do_reset();
      for (int i = 0; i < 11; i++) begin
         req_valid = tab[i].v;
         fifo_full = tab[i].f;
         req_data0 = tab[i].d0;
         req_data1 = 8'h5A;
         req_data2 = 8'hC3;
         #2;
         chk("tab_grant", 16'(grant), 16'(tab[i].eg));
         chk("tab_busy",  16'(busy), 16'(tab[i].eg != 3'b000));
         chk("tab_wr",    16'(fifo_wr_enb), 16'(tab[i].ew));
         chk("tab_data",  16'(fifo_data_in), 16'(tab[i].ed));
         @(posedge clk);
         #1;
      end

      // All three requesting: 001, 010, 100, 001 with one bubble between.
      do_reset();
      for (int c = 0; c < 21; c++) begin
         cycle(3'b111, 1'b0, rnd8(), rnd8(), rnd8());
         case (c)
            1:  chk("rr_first",  16'(grant_seen), 16'h1);
            5:  chk("rr_bubble", 16'(grant_seen), 16'h0);
            6:  chk("rr_second", 16'(grant_seen), 16'h2);
            11: chk("rr_third",  16'(grant_seen), 16'h4);
            16: chk("rr_wrap",   16'(grant_seen), 16'h1);
            default: ;
         endcase
      end

      // Requester 1 drops valid after two beats; requester 2 follows.
      do_reset();
      model_reset();
      last = 0;
      // Route the first grant to requester 1 by presenting only its valid.
      last = 2;
      wr_seen = 0;
      cycle(3'b010, 1'b0, rnd8(), rnd8(), rnd8());
      cycle(3'b010, 1'b0, rnd8(), rnd8(), rnd8());
      cycle(3'b010, 1'b0, rnd8(), rnd8(), rnd8());
      cycle(3'b100, 1'b0, rnd8(), rnd8(), rnd8());
      cycle(3'b100, 1'b0, rnd8(), rnd8(), rnd8());
      chk("drop_release", 16'(grant_seen), 16'h0);
      chk("drop_beats",   16'(wr_seen), 16'd2);
      cycle(3'b100, 1'b0, rnd8(), rnd8(), rnd8());
      chk("drop_next", 16'(grant_seen), 16'h4);

      // FIFO full for five cycles in the middle of a burst.
      do_reset();
      wr_seen = 0;
      cycle(3'b001, 1'b0, rnd8(), rnd8(), rnd8());
      cycle(3'b001, 1'b0, rnd8(), rnd8(), rnd8());
      cycle(3'b001, 1'b0, rnd8(), rnd8(), rnd8());
`ifdef FIFO_WR_ARB_STALL_CNT_EN
      s0 = int'(stall_cnt);
`else
      s0 = 0;
`endif
      repeat (5) cycle(3'b001, 1'b1, rnd8(), rnd8(), rnd8());
      chk("full_hold", 16'(grant), 16'h1);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
      chk("full_stall", 16'(int'(stall_cnt) - s0), 16'd5);
`endif
      cycle(3'b001, 1'b0, rnd8(), rnd8(), rnd8());
      cycle(3'b001, 1'b0, rnd8(), rnd8(), rnd8());
      cycle(3'b000, 1'b0, rnd8(), rnd8(), rnd8());
      chk("full_beats", 16'(wr_seen + s0 - s0), 16'd4);
      chk("full_done",  16'(grant_seen), 16'h0);

      // Asynchronous reset between edges in the middle of a burst.
      do_reset();
      cycle(3'b011, 1'b0, rnd8(), rnd8(), rnd8());
      cycle(3'b011, 1'b0, rnd8(), rnd8(), rnd8());
      cycle(3'b011, 1'b0, rnd8(), rnd8(), rnd8());
      #2;
      rst = 1'b0;
      #1;
      chk("arst_grant", 16'(grant), 16'h0);
      chk("arst_busy",  16'(busy), 16'h0);
      chk("arst_wr",    16'(fifo_wr_enb), 16'h0);
      chk("arst_ready", 16'(req_ready), 16'h0);
      #1;
      rst = 1'b1;
      model_reset();
      cycle(3'b111, 1'b0, rnd8(), rnd8(), rnd8());
      cycle(3'b111, 1'b0, rnd8(), rnd8(), rnd8());
      chk("arst_first", 16'(grant_seen), 16'h1);

      // Randomized traffic against the reference model.
      do_reset();
      v = 3'b000;
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 3) == 0) v = 3'($urandom_range(0, 7));
         cycle(v, ($urandom_range(0, 3) == 0), rnd8(), rnd8(), rnd8());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter: BURST, 4, maximum accepted beats per grant (legal 1..8).
REQ-002 SHALL have parameter: DW, 8, data width of every data port.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: req_valid  input  3  per-requester data-valid; bit i belongs to requester i.
REQ-006 SHALL have port: req_data0, req_data1, req_data2  input  DW each  requester payloads.
REQ-007 SHALL have port: req_ready  output  3  per-requester accept; beat transfers when req_valid[i] & req_ready[i].
REQ-008 SHALL have port: fifo_full  input  1  full flag of the downstream 8-entry FIFO.
REQ-009 SHALL have port: fifo_wr_enb  output  1  write enable to the FIFO.
REQ-010 SHALL have port: fifo_data_in  output  DW  write data to the FIFO.
REQ-011 SHALL have port: grant  output  3  one-hot registered grant; 3'b000 when no grant.
REQ-012 SHALL have port: busy  output  1  high while state is GRANT.

Function
REQ-013 SHALL implement two states: IDLE, GRANT.
REQ-014 SHALL in IDLE, if any req_valid bit is set, register a one-hot grant and enter GRANT on the next edge; else remain in IDLE with grant = 0.
REQ-015 SHALL select the grant round-robin: search order starts at the requester after the last granted one (after reset, search starts at requester 0).
REQ-016 SHALL drive req_ready[i] = (state==GRANT) & grant[i] & !fifo_full, combinationally; all other bits 0.
REQ-017 SHALL drive fifo_wr_enb = |(req_valid & req_ready) and fifo_data_in = payload of the granted requester, both combinationally (zero-cycle latency); fifo_data_in = 0 when no grant.
REQ-018 SHALL keep a beat counter (0..BURST-1), cleared on entry to GRANT, incremented per accepted beat.
REQ-019 SHALL release the grant (GRANT->IDLE, grant->0, last-granted pointer updated) on the edge where an accepted beat occurs with beat counter == BURST-1.
REQ-020 SHALL release the grant on the edge where the granted requester's req_valid is 0 while in GRANT.
REQ-021 SHALL while fifo_full is high in GRANT with valid held: accept no beat, hold grant and beat counter, never time out.
REQ-022 SHALL insert exactly one IDLE cycle between consecutive grants (arbitration bubble).
REQ-023 SHALL ignore non-granted req_valid changes during GRANT.
REQ-024 SHALL never assert fifo_wr_enb while fifo_full is high.

Reset
REQ-025 SHALL on rst low, immediately and asynchronously: state=IDLE, grant=0, busy=0, beat counter=0, round-robin pointer=requester 2 (so requester 0 searched first).
REQ-026 SHALL force req_ready=0 and fifo_wr_enb=0 during reset, including reset asserted mid-burst; the interrupted burst is abandoned, not resumed.
REQ-027 SHALL leave IDLE no earlier than the first rising edge after rst deasserts.

Configuration
REQ-028 SHALL, with macro FIFO_WR_ARB_STALL_CNT_EN defined, add output port stall_cnt (16 bits), reset to 0, incrementing each cycle in which state==GRANT, granted req_valid=1 and fifo_full=1, saturating at 16'hFFFF.
REQ-029 SHALL, without FIFO_WR_ARB_STALL_CNT_EN, omit the stall_cnt port and its logic; all other behaviour identical.

Verification
REQ-030 SHALL cover: reset, then req_valid=3'b001 held, data 8'hA0..A7, fifo_full=0 -> grant=001 after 1 cycle, 4 beats A0..A3 written, 1 idle cycle, then A4..A7 in the second grant.
REQ-031 SHALL cover: req_valid=3'b111 held, BURST=4 -> grant order 001,010,100,001, each 4 beats, one bubble between each.
REQ-032 SHALL cover: requester 1 granted, drops valid after 2 beats -> release on that edge, beat count 2, next grant goes to requester 2 if valid.
REQ-033 SHALL cover: fifo_full=1 for 5 cycles mid-burst -> fifo_wr_enb=0, req_ready=0, grant held; burst completes remaining beats after full clears; with FIFO_WR_ARB_STALL_CNT_EN stall_cnt increases by 5.
REQ-034 SHALL cover: rst driven low mid-burst between clock edges -> grant=0, busy=0, fifo_wr_enb=0 immediately; after release, requester 0 wins first with valid=3'b111.
